mux_nto1_reg: RTL and testbench
===============================

// Module: mux_nto1_reg
// PURPOSE
//  Parametrised N-input, W-bit registered multiplexer; successor to the 2:1 mux family.
//  Adds a registered output with valid/ready handshake and two modes: fixed select, or
//  auto-scan (round-robin pointer). Feeds downstream serial/display logic one channel per beat.
// PARAMETERS
//  WIDTH   8  data width per channel
//  NUM_IN  4  number of input channels (>=2)
//  SEL_W   2  select/pointer width, = clog2(NUM_IN)
// PORTS
//  clk        in   1              rising-edge clock
//  rst_n      in   1              asynchronous reset, active-low
//  in_bus     in   NUM_IN*WIDTH   packed inputs; ch k = in_bus[k*WIDTH +: WIDTH]
//  sel        in   SEL_W          channel select, mode 0 only
//  mode       in   1              0 = fixed select, 1 = auto-scan
//  en         in   1              capture request
//  out_ready  in   1              downstream accepts out_data this cycle
//  out_data   out  WIDTH          registered selected data
//  out_ch     out  SEL_W          channel index of out_data
//  out_valid  out  1              out_data/out_ch hold a beat
// BEHAVIOUR
//  - Reset (rst_n=0, async): out_data=0, out_ch=0, out_valid=0, ptr=0.
//  - load = en & (~out_valid | out_ready). Capture on the clk edge where load=1.
//    Latency: 1 cycle from inputs sampled to out_valid=1.
//  - Stall: out_valid=1 & out_ready=0 -> out_data, out_ch, out_valid, ptr all hold.
//  - Drain: out_valid=1 & out_ready=1 & en=0 -> out_valid=0 next cycle; data holds.
//  - Mode 0: capture ch=sel; out_ch<=sel. sel>=NUM_IN -> out_data<=0, out_ch<=sel.
//    ptr forced to 0 every cycle mode=0.
//  - Mode 1: capture ch=ptr; out_ch<=ptr; ptr<=ptr+1 on load, wraps NUM_IN-1 -> 0.
//    sel ignored. ptr changes only on load.
//  - Mode change takes effect on the next load; a stalled beat is never altered.
//  - Back-to-back: out_ready=1 and en=1 continuously -> one new beat per cycle.
//  - Data is sampled at capture edge only; in_bus changes during stall are ignored.
//  - Reset mid-stream: all state cleared immediately; scan restarts at ch 0.
// CONFIGURATION
//  MUX_SKIP_MASK_EN defined: adds input ch_mask [NUM_IN-1:0] (1 = skip channel).
//   Mode 1: capture channel = first unmasked at or after ptr (cyclic search);
//   ptr <= that channel+1 (wrapped). All channels masked -> no capture, out_valid
//   follows drain rule, ptr holds. Mode 0: masked sel -> no capture (treated as en=0).
//  Not defined: no ch_mask port; all channels eligible; behaviour as above.
// TESTING  (WIDTH=8, NUM_IN=4; ch0..3 = 8'h11,8'h22,8'h33,8'h44)
//  1 Reset: rst_n=0 mid-cycle -> out_valid=0, out_data=0, out_ch=0 without clock edge.
//  2 Mode 0, sel=2, en=1, out_ready=1 -> next cycle out_data=8'h33, out_ch=2, out_valid=1.
//  3 Mode 1, en=1, out_ready=1 for 6 cycles -> out_data 11,22,33,44,11,22; out_ch 0,1,2,3,0,1.
//  4 Mode 1, out_ready=0 after first beat for 3 cycles -> out_data stays 8'h11, ptr stays 1;
//    out_ready=1 -> next beat 8'h22.
//  5 en=0 with out_valid=1, out_ready=1 -> out_valid=0 next cycle, out_data holds value.
//  6 MUX_SKIP_MASK_EN, mode 1, ch_mask=4'b0101 -> out_data 22,44,22,44;
//    ch_mask=4'b1111 -> out_valid drops after consume, no new beat.

Source files
------------

// File: rtl/mux_nto1_reg.sv
// mux_nto1_reg: N-input, W-bit registered multiplexer with valid/ready output.
// Two modes: fixed select (mode=0) or round-robin auto-scan (mode=1).
// Optional feature macro: MUX_SKIP_MASK_EN adds ch_mask (1 = skip channel).
//
// Handshake: a beat is held in out_data/out_ch while out_valid=1 and is
// consumed on a rising edge where out_valid=1 and out_ready=1. A new beat is
// captured on any edge where en=1 and the output register is free
// (out_valid=0) or being consumed in that same edge (out_ready=1). A held,
// unconsumed beat is never altered.
module mux_nto1_reg #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    mode,
    input  logic                    en,
`ifdef MUX_SKIP_MASK_EN
    input  logic [NUM_IN-1:0]       ch_mask,
`endif
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid
);

    logic [WIDTH-1:0]  r_data;
    logic [SEL_W-1:0]  r_ch;
    logic              r_valid;
    logic [SEL_W-1:0]  r_ptr;

    logic [NUM_IN-1:0] w_skip;
    logic [SEL_W-1:0]  w_scan_ch;
    logic              w_scan_found;
    int                w_dist;
    int                w_best;
    logic              w_sel_ok;
    logic [SEL_W-1:0]  w_ch;
    logic              w_eligible;
    logic [WIDTH-1:0]  w_data;
    logic [SEL_W-1:0]  w_ptr_next;
    logic              w_load;

`ifdef MUX_SKIP_MASK_EN
    assign w_skip = ch_mask;
`else
    assign w_skip = '0;
`endif

    // Scan mode: nearest non-skipped channel at or after the pointer, cyclically.
    always_comb begin
        w_scan_ch    = r_ptr;
        w_scan_found = 1'b0;
        w_best       = NUM_IN;
        w_dist       = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            w_dist = k - int'(r_ptr);
            if (w_dist < 0) begin
                w_dist = w_dist + NUM_IN;
            end
            if (!w_skip[k] && (w_dist < w_best)) begin
                w_best       = w_dist;
                w_scan_ch    = SEL_W'(k);
                w_scan_found = 1'b1;
            end
        end
    end

    // Fixed mode: a skipped in-range select behaves as if en were low.
    always_comb begin
        w_sel_ok = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if ((int'(sel) == k) && w_skip[k]) begin
                w_sel_ok = 1'b0;
            end
        end
    end

    // Channel choice and data mux; an out-of-range select yields zero data.
    always_comb begin
        w_ch       = mode ? w_scan_ch : sel;
        w_eligible = mode ? w_scan_found : w_sel_ok;
        w_data     = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(w_ch) == k) begin
                w_data = in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    // Pointer advances past the captured channel, wrapping at the last channel.
    always_comb begin
        if (int'(w_scan_ch) >= NUM_IN - 1) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = w_scan_ch + SEL_W'(1);
        end
    end

    assign w_load = en && w_eligible && (!r_valid || out_ready);

    // Output register: capture on load, drop valid when consumed without a refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_data  <= w_data;
            r_ch    <= w_ch;
            r_valid <= 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Scan pointer: parked at 0 in fixed mode, advances only on a scan capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (!mode) begin
            r_ptr <= '0;
        end else if (w_load) begin
            r_ptr <= w_ptr_next;
        end
    end

    assign out_data  = r_data;
    assign out_ch    = r_ch;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Directed bench for mux_nto1_reg (WIDTH=8, NUM_IN=4).
// Channel data: ch0..ch3 = 8'h11, 8'h22, 8'h33, 8'h44.
module tb_mux_nto1_reg;

  localparam int WIDTH  = 8;
  localparam int NUM_IN = 4;
  localparam int SEL_W  = 2;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_IN*WIDTH-1:0] in_bus;
  logic [SEL_W-1:0]        sel;
  logic                    mode;
  logic                    en;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_valid;
`ifdef MUX_SKIP_MASK_EN
  logic [NUM_IN-1:0]       ch_mask;
`endif

  int n_checks;
  int n_fail;
  logic [WIDTH-1:0] exp_q[$];
  logic [SEL_W-1:0] exp_ch_q[$];

  mux_nto1_reg #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bus    (in_bus),
    .sel       (sel),
    .mode      (mode),
    .en        (en),
`ifdef MUX_SKIP_MASK_EN
    .ch_mask   (ch_mask),
`endif
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic m, input logic [SEL_W-1:0] s, input logic e, input logic r);
    mode      = m;
    sel       = s;
    en        = e;
    out_ready = r;
  endtask

  // checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_beat(input string tag, input logic v, input logic [WIDTH-1:0] d,
                            input logic [SEL_W-1:0] c);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".data"},  32'(out_data),  32'(d));
    check({tag, ".ch"},    32'(out_ch),    32'(c));
  endtask

  // scoreboard: compare one captured beat against the head of the expected queues
  task automatic score_beat(input string tag);
    logic [WIDTH-1:0] ed;
    logic [SEL_W-1:0] ec;
    if (exp_q.size() == 0 || exp_ch_q.size() == 0) begin
      check({tag, ".queue_empty"}, 32'd1, 32'd0);
    end else begin
      ed = exp_q.pop_front();
      ec = exp_ch_q.pop_front();
      check_beat(tag, 1'b1, ed, ec);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    in_bus    = {8'h44, 8'h33, 8'h22, 8'h11};
    drive(1'b0, 2'd0, 1'b0, 1'b0);
    rst_n     = 1'b0;
`ifdef MUX_SKIP_MASK_EN
    ch_mask   = '0;
`endif
    tick();
    check_beat("reset", 1'b0, 8'h00, 2'd0);
    rst_n = 1'b1;
    tick();
    check_beat("idle", 1'b0, 8'h00, 2'd0);

    // fixed select, sel=2
    drive(1'b0, 2'd2, 1'b1, 1'b1);
    tick();
    check_beat("m0_sel2", 1'b1, 8'h33, 2'd2);

    // drain: valid drops, data holds
    drive(1'b0, 2'd2, 1'b0, 1'b1);
    tick();
    check_beat("m0_drain", 1'b0, 8'h33, 2'd2);

    // asynchronous reset with no clock edge
    drive(1'b0, 2'd3, 1'b1, 1'b1);
    tick();
    check_beat("m0_sel3", 1'b1, 8'h44, 2'd3);
    drive(1'b0, 2'd3, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_beat("async_rst", 1'b0, 8'h00, 2'd0);
    tick();
    rst_n = 1'b1;

    // auto-scan, back-to-back for 6 cycles
    exp_q    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22};
    exp_ch_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    drive(1'b1, 2'd3, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      score_beat($sformatf("scan%0d", i));
    end

    // reset mid-stream: scan restarts at ch0
    drive(1'b1, 2'd0, 1'b0, 1'b0);
    do_reset();
    drive(1'b1, 2'd2, 1'b1, 1'b1);
    tick();
    check_beat("stall_first", 1'b1, 8'h11, 2'd0);

    // stall for 3 cycles, input change ignored
    out_ready = 1'b0;
    in_bus[7:0] = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_beat($sformatf("stall%0d", i), 1'b1, 8'h11, 2'd0);
    end
    in_bus[7:0] = 8'h11;
    out_ready = 1'b1;
    tick();
    check_beat("stall_release", 1'b1, 8'h22, 2'd1);
    tick();
    check_beat("after_stall", 1'b1, 8'h33, 2'd2);

    // drain in scan mode, data holds over two cycles
    drive(1'b1, 2'd0, 1'b0, 1'b1);
    tick();
    check_beat("scan_drain0", 1'b0, 8'h33, 2'd2);
    tick();
    check_beat("scan_drain1", 1'b0, 8'h33, 2'd2);

    // mode change while stalled leaves the held beat alone
    drive(1'b1, 2'd0, 1'b1, 1'b1);
    tick();
    check_beat("scan_ch3", 1'b1, 8'h44, 2'd3);
    drive(1'b0, 2'd1, 1'b1, 1'b0);
    tick();
    check_beat("modechg_stall", 1'b1, 8'h44, 2'd3);
    out_ready = 1'b1;
    tick();
    check_beat("modechg_m0", 1'b1, 8'h22, 2'd1);
    // pointer was parked at 0 during fixed mode
    drive(1'b1, 2'd3, 1'b1, 1'b1);
    tick();
    check_beat("ptr_parked", 1'b1, 8'h11, 2'd0);

    // fixed select back-to-back with changing sel
    drive(1'b0, 2'd3, 1'b1, 1'b1);
    tick();
    check_beat("b2b_sel3", 1'b1, 8'h44, 2'd3);
    sel = 2'd0;
    tick();
    check_beat("b2b_sel0", 1'b1, 8'h11, 2'd0);

`ifdef MUX_SKIP_MASK_EN
    drive(1'b1, 2'd0, 1'b0, 1'b0);
    do_reset();
    ch_mask  = 4'b0101;
    exp_q    = '{8'h22, 8'h44, 8'h22, 8'h44};
    exp_ch_q = '{2'd1, 2'd3, 2'd1, 2'd3};
    drive(1'b1, 2'd0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      score_beat($sformatf("mask%0d", i));
    end
    ch_mask = 4'b1111;
    tick();
    check_beat("mask_all0", 1'b0, 8'h44, 2'd3);
    tick();
    check_beat("mask_all1", 1'b0, 8'h44, 2'd3);
    ch_mask = 4'b0001;
    drive(1'b0, 2'd0, 1'b1, 1'b1);
    tick();
    check_beat("mask_m0_skip", 1'b0, 8'h44, 2'd3);
    sel = 2'd2;
    tick();
    check_beat("mask_m0_ok", 1'b1, 8'h33, 2'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
